// File: rtl/mux_8bit_2ch.sv
// Two-channel byte selector: combinational output O plus a registered copy,
// a registered select and a counter of select changes seen on enabled edges.
`timescale 1ns/1ps
module mux_8bit_2ch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             en,
    output logic [WIDTH-1:0] O,
    output logic [WIDTH-1:0] O_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] sw_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] o_q_reg;
    logic [WIDTH-1:0] o_q_next;
    logic             sel_q_reg;
    logic [CNT_W-1:0] sw_cnt_reg;
    logic [CNT_W-1:0] sw_cnt_next;

    // Per-bit select keeps O a pure function of sel/A/B with no clock involvement.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign O[gi] = (sel == 1'b0) ? A[gi] : B[gi];
        end
    endgenerate

    always_comb begin
        o_q_next    = O;
        sw_cnt_next = sw_cnt_reg;
        if (sel != sel_q_reg) begin
            sw_cnt_next = sw_cnt_reg + CNT_ONE;
        end
    end

    // Reset wins over en; the counter wraps naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_q_reg    <= '0;
            sel_q_reg  <= 1'b0;
            sw_cnt_reg <= '0;
        end else if (en) begin
            o_q_reg    <= o_q_next;
            sel_q_reg  <= sel;
            sw_cnt_reg <= sw_cnt_next;
        end
    end

    assign O_q    = o_q_reg;
    assign sel_q  = sel_q_reg;
    assign sw_cnt = sw_cnt_reg;

endmodule

// File: tb/tb_mux_8bit_2ch.sv
// Scoreboard bench for mux_8bit_2ch: stimulus queues expected results,
// a monitor process samples the DUTs and compares.
`timescale 1ns/1ps
module tb_mux_8bit_2ch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        sel = 1'b0;
    logic [7:0]  a = 8'h00;
    logic [7:0]  b = 8'h00;
    logic        en = 1'b0;
    logic [7:0]  o, oq, o4, oq4;
    logic        selq, selq4;
    logic [15:0] cnt;
    logic [3:0]  cnt4;

    always #5 clk = ~clk;

    mux_8bit_2ch dut (
        .clk(clk), .rst_n(rst_n), .sel(sel), .A(a), .B(b), .en(en),
        .O(o), .O_q(oq), .sel_q(selq), .sw_cnt(cnt)
    );

    mux_8bit_2ch #(.WIDTH(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .sel(sel), .A(a), .B(b), .en(en),
        .O(o4), .O_q(oq4), .sel_q(selq4), .sw_cnt(cnt4)
    );

    typedef struct {
        string       name;
        bit          regs;
        logic [7:0]  o;
        logic [7:0]  oq;
        logic        selq;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    event sample_ev;
    int   checks = 0;
    int   passes = 0;

    task automatic push(string nm, bit regs, logic [7:0] eo, logic [7:0] eoq,
                        logic esq, logic [15:0] ec, logic [3:0] ec4);
        exp_t e;
        e.name = nm; e.regs = regs; e.o = eo; e.oq = eoq;
        e.selq = esq; e.cnt = ec; e.cnt4 = ec4;
        q.push_back(e);
        -> sample_ev;
    endtask

    task automatic cmp(string nm, string fld, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req)
            $display("FAIL %s.%s: got %0h required %0h", nm, fld, act, req);
        else
            passes++;
    endtask

    // Monitor: samples 1 ns after each stimulus notification, away from clock edges.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            while (q.size() > 0) begin
                e = q.pop_front();
                cmp(e.name, "O", 32'(o), 32'(e.o));
                if (e.regs) begin
                    cmp(e.name, "O_q", 32'(oq), 32'(e.oq));
                    cmp(e.name, "sel_q", 32'(selq), 32'(e.selq));
                    cmp(e.name, "sw_cnt", 32'(cnt), 32'(e.cnt));
                    cmp(e.name, "O_q4", 32'(oq4), 32'(e.oq));
                    cmp(e.name, "sel_q4", 32'(selq4), 32'(e.selq));
                    cmp(e.name, "sw_cnt4", 32'(cnt4), 32'(e.cnt4));
                end
                $display("txn %-12s sel=%0b A=%02h B=%02h O=%02h O_q=%02h sel_q=%0b sw_cnt=%0d sw_cnt4=%0d",
                         e.name, sel, a, b, o, oq, selq, cnt, cnt4);
            end
        end
    end

    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] a_tab [9];
    logic [7:0] b_tab [5];

    initial begin
        a_tab = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd200, 8'd250, 8'd44, 8'd94, 8'd144};
        b_tab = '{8'd0, 8'd37, 8'd74, 8'd111, 8'd148};

        // Reset with inputs active: O tracks B immediately, registers clear.
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; a = 8'hAA; b = 8'h55; sel = 1'b1;
        #1 push("rst_comb", 0, 8'h55, 8'h00, 1'b0, 16'd0, 4'd0);
        edge_then_sample();
        push("rst_edge1", 1, 8'h55, 8'h00, 1'b0, 16'd0, 4'd0);
        edge_then_sample();
        push("rst_edge2", 1, 8'h55, 8'h00, 1'b0, 16'd0, 4'd0);

        // Alternating select on successive enabled edges.
        @(negedge clk);
        rst_n = 1'b1; a = 8'h11; b = 8'h22;
        sel = 1'b0; edge_then_sample(); push("alt0", 1, 8'h11, 8'h11, 1'b0, 16'd0, 4'd0);
        @(negedge clk);
        sel = 1'b1; edge_then_sample(); push("alt1", 1, 8'h22, 8'h22, 1'b1, 16'd1, 4'd1);
        @(negedge clk);
        sel = 1'b0; edge_then_sample(); push("alt2", 1, 8'h11, 8'h11, 1'b0, 16'd2, 4'd2);
        @(negedge clk);
        sel = 1'b1; edge_then_sample(); push("alt3", 1, 8'h22, 8'h22, 1'b1, 16'd3, 4'd3);

        // en low: O follows, registers hold.
        @(negedge clk);
        en = 1'b0; sel = 1'b0; a = 8'h33; b = 8'h44;
        #1 push("hold_comb0", 0, 8'h33, 8'h00, 1'b0, 16'd0, 4'd0);
        edge_then_sample();
        push("hold0", 1, 8'h33, 8'h22, 1'b1, 16'd3, 4'd3);
        @(negedge clk);
        sel = 1'b1; a = 8'h5A; b = 8'h66;
        #1 push("hold_comb1", 0, 8'h66, 8'h00, 1'b0, 16'd0, 4'd0);
        edge_then_sample();
        push("hold1", 1, 8'h66, 8'h22, 1'b1, 16'd3, 4'd3);
        @(negedge clk);
        en = 1'b1; sel = 1'b0; a = 8'h33;
        edge_then_sample();
        push("reenable", 1, 8'h33, 8'h33, 1'b0, 16'd4, 4'd4);

        // Pure combinational changes, registers frozen.
        @(negedge clk);
        en = 1'b0; a = 8'd0; b = 8'd0; sel = 1'b0;
        #1 push("comb_zero", 0, 8'd0, 8'd0, 1'b0, 16'd0, 4'd0);
        #3 a = 8'd50;
        #1 push("comb_a50", 0, 8'd50, 8'd0, 1'b0, 16'd0, 4'd0);
        #3 sel = 1'b1;
        #1 push("comb_sel1", 0, 8'd0, 8'd0, 1'b0, 16'd0, 4'd0);
        #3 b = 8'd37;
        #1 push("comb_b37", 0, 8'd37, 8'd0, 1'b0, 16'd0, 4'd0);
        #3;

        // Free-running pattern over 80 ns: sel every 5, A every 10, B every 20.
        for (int k = 0; k <= 16; k++) begin
            sel = k[0];
            a = a_tab[k / 2];
            b = b_tab[k / 4];
            #1 push($sformatf("free_%0d", k), 0, k[0] ? b_tab[k / 4] : a_tab[k / 2],
                    8'd0, 1'b0, 16'd0, 4'd0);
            #4;
        end

        // Wrap test: reset, then toggle sel on every enabled edge.
        @(negedge clk);
        rst_n = 1'b0; en = 1'b1; sel = 1'b0; a = 8'h0F; b = 8'hF0;
        edge_then_sample();
        push("wrap_rst", 1, 8'h0F, 8'h00, 1'b0, 16'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i > 1) @(negedge clk);
            sel = i[0];
            edge_then_sample();
            if (i >= 14)
                push($sformatf("wrap_%0d", i), 1, i[0] ? 8'hF0 : 8'h0F, i[0] ? 8'hF0 : 8'h0F,
                     i[0], 16'(i), 4'(i));
        end
        @(negedge clk);
        sel = 1'b0; rst_n = 1'b0;
        edge_then_sample();
        push("mid_rst", 1, 8'h0F, 8'h00, 1'b0, 16'd0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;

        #5;
        checks++;
        if (q.size() != 0)
            $display("FAIL drain: got %0d pending required 0", q.size());
        else
            passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
